fsb_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one outbound FSB master link between several FSB packet sources. The sources are the AXI-Lite and AXI4 slave-side adapters in the AXI/FSB adapter layer. Each source offers packets on a valid/yumi interface. The arbiter selects one winner per cycle, registers the packet in a single-entry output stage, and drives the FSB link on a valid/ready interface. Per-source grant counters are exposed to the host-visible config space for debug.

---
 rtl/fsb_arb_pkg.sv | 16 +
 rtl/fsb_rr_arbiter_if.sv | 27 ++
 rtl/fsb_rr_arb_core.sv | 38 +++
 rtl/fsb_rr_arbiter.sv | 84 ++++++++
 tb/tb_fsb_rr_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fsb_arb_pkg.sv
// Shared constants and helpers for the FSB round-robin arbiter.
package fsb_arb_pkg;

  // Default width of each per-source grant counter.
  localparam int cnt_width_default = 16;

  // Largest supported number of requesting sources.
  localparam int max_req = 8;

  // Width of a source index. Never returns less than 1, so a
  // degenerate requester count still gets a legal vector width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsb_rr_arbiter_if.sv
// Request side (valid/yumi) and FSB link side (valid/ready) of the arbiter.
// The master modport is the arbiter, which masters the outbound FSB link.
// The slave modport is the environment: the sources plus the downstream sink.
interface fsb_rr_arbiter_if #(
  parameter int num_req_p   = 2,
  parameter int fsb_width_p = 80
);
  localparam int idx_w = fsb_arb_pkg::idx_width(num_req_p);

  logic [num_req_p-1:0]             req_v;
  logic [num_req_p*fsb_width_p-1:0] req_data;
  logic [num_req_p-1:0]             req_yumi;
  logic                             fsb_v;
  logic [fsb_width_p-1:0]           fsb_data;
  logic [idx_w-1:0]                 fsb_src;
  logic                             fsb_ready;

  modport master (
    input  req_v, req_data, fsb_ready,
    output req_yumi, fsb_v, fsb_data, fsb_src
  );

  modport slave (
    output req_v, req_data, fsb_ready,
    input  req_yumi, fsb_v, fsb_data, fsb_src
  );
endinterface

// File: rtl/fsb_rr_arb_core.sv
// Combinational rotate-priority arbiter. The scan starts at rr_ptr and wraps
// modulo num_req_p. It produces a one-hot grant and the index of the winner.
module fsb_rr_arb_core
  import fsb_arb_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int idx_w_p   = idx_width(num_req_p)
) (
  input  logic [num_req_p-1:0] req,
  input  logic [idx_w_p-1:0]   rr_ptr,
  input  logic                 en,
  output logic [num_req_p-1:0] gnt,
  output logic [idx_w_p-1:0]   winner
);

  logic [num_req_p-1:0] rot;
  logic                 hit;
  int                   w;

  // Rotate the request vector so that rr_ptr sits at bit 0, then find the
  // first set bit and map it back to a source index.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the block can leave one unassigned and infer a latch.
    rot = num_req_p'({req, req} >> rr_ptr);
    hit = 1'b0;
    w   = 0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!hit && rot[i]) begin
        hit = 1'b1;
        w   = int'(rr_ptr) + i;
      end
    end
    if (w >= num_req_p) w = w - num_req_p;
    winner = idx_w_p'(w);
    gnt    = (en && hit) ? (num_req_p'(1) << winner) : '0;
  end

endmodule

// File: rtl/fsb_rr_arbiter.sv
// Round-robin arbiter that multiplexes several valid/yumi packet sources onto
// one valid/ready FSB link. It has a single-entry registered output stage and
// saturating per-source grant counters for debug.
module fsb_rr_arbiter
  import fsb_arb_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int fsb_width_p = 80,
  parameter int cnt_width_p = cnt_width_default
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  fsb_rr_arbiter_if.master                 bus,
  input  logic                             cnt_clear_i,
  output logic [num_req_p*cnt_width_p-1:0] gnt_cnt_o
);

  localparam int idx_w = idx_width(num_req_p);

  logic                   slot_free;
  logic                   arb_en;
  logic                   grant;
  logic [num_req_p-1:0]   gnt;
  logic [idx_w-1:0]       winner;
  logic [idx_w-1:0]       rr_ptr;
  logic [fsb_width_p-1:0] pkt     [num_req_p];
  logic [cnt_width_p-1:0] gnt_cnt [num_req_p];

  // The slot may take a new packet if it is empty or is draining this cycle.
  // Reset gates the grant, so no yumi escapes while the stage is cleared.
  assign slot_free    = ~bus.fsb_v | bus.fsb_ready;
  assign arb_en       = slot_free & ~reset_i;
  assign grant        = |gnt;
  assign bus.req_yumi = gnt;

  for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
    assign pkt[k] = bus.req_data[k*fsb_width_p +: fsb_width_p];
    assign gnt_cnt_o[k*cnt_width_p +: cnt_width_p] = gnt_cnt[k];
  end

  fsb_rr_arb_core #(
    .num_req_p (num_req_p),
    .idx_w_p   (idx_w)
  ) u_core (
    .req    (bus.req_v),
    .rr_ptr (rr_ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .winner (winner)
  );

  // Output stage and round-robin pointer: load on a grant, empty on a drain,
  // and hold otherwise.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset_i) begin
      bus.fsb_v    <= 1'b0;
      bus.fsb_data <= '0;
      bus.fsb_src  <= '0;
      rr_ptr       <= '0;
    end else if (grant) begin
      bus.fsb_v    <= 1'b1;
      bus.fsb_data <= pkt[winner];
      bus.fsb_src  <= winner;
      rr_ptr       <= (winner == idx_w'(num_req_p - 1)) ? '0 : winner + idx_w'(1);
    end else if (bus.fsb_ready) begin
      bus.fsb_v    <= 1'b0;
    end
  end

  // Per-source grant counters. They saturate, and a clear beats a grant in
  // the same cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: this counter array is a small bank of flops rather than a RAM, so it is cleared in reset like any other register.
    if (reset_i || cnt_clear_i) begin
      for (int k = 0; k < num_req_p; k++) gnt_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < num_req_p; k++) begin
        if (gnt[k] && (gnt_cnt[k] != '1)) gnt_cnt[k] <= gnt_cnt[k] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsb_rr_arbiter.sv
// Self-checking bench for fsb_rr_arbiter. A 2-source instance is driven against
// a cycle model and a packet scoreboard. A 3-source instance with 4-bit
// counters covers non-power-of-two wrap, counter saturation and clear.
module tb_fsb_rr_arbiter;

  localparam int fw = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, clr2, rst3, clr3;
  logic [31:0] gnt_cnt2;
  logic [11:0] gnt_cnt3;

  fsb_rr_arbiter_if #(.num_req_p(2), .fsb_width_p(fw)) i2 ();
  fsb_rr_arbiter_if #(.num_req_p(3), .fsb_width_p(fw)) i3 ();

  fsb_rr_arbiter #(.num_req_p(2), .fsb_width_p(fw), .cnt_width_p(16)) u2 (
    .clk_i(clk), .reset_i(rst2), .bus(i2), .cnt_clear_i(clr2), .gnt_cnt_o(gnt_cnt2)
  );

  fsb_rr_arbiter #(.num_req_p(3), .fsb_width_p(fw), .cnt_width_p(4)) u3 (
    .clk_i(clk), .reset_i(rst3), .bus(i3), .cnt_clear_i(clr3), .gnt_cnt_o(gnt_cnt3)
  );

  typedef struct packed {
    logic          src;
    logic [fw-1:0] data;
  } pkt2_t;

  pkt2_t         sb[$];
  logic          m_v;
  logic [fw-1:0] m_data;
  logic          m_src;
  logic          m_ptr;
  logic [15:0]   m_cnt [2];
  logic [fw-1:0] d2 [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of the 2-source instance. The model predicts the yumi, and the
  // predicted packet goes to the scoreboard. After the edge, the output stage
  // is checked against the popped entry or the held value.
  task automatic step2(input logic rst, input logic [1:0] v, input logic rdy, input logic clr);
    logic  g;
    logic  w;
    pkt2_t e;
    @(negedge clk);
    rst2        = rst;
    clr2        = clr;
    i2.req_v    = v;
    i2.fsb_ready = rdy;
    i2.req_data = {d2[1], d2[0]};
    #1;
    g = 1'b0;
    w = 1'b0;
    if (!rst && (!m_v || rdy)) begin
      if (v[m_ptr]) begin
        g = 1'b1; w = m_ptr;
      end else if (v[~m_ptr]) begin
        g = 1'b1; w = ~m_ptr;
      end
    end
    check("u2_yumi", i2.req_yumi, g ? (2'b01 << w) : 2'b00);
    if (g) begin
      e.src  = w;
      e.data = d2[w];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_v = 1'b0; m_data = '0; m_src = 1'b0; m_ptr = 1'b0;
    end else if (g) begin
      e      = sb.pop_front();
      m_v    = 1'b1;
      m_data = e.data;
      m_src  = e.src;
      m_ptr  = ~w;
    end else if (rdy) begin
      m_v = 1'b0;
    end
    if (rst || clr) begin
      m_cnt[0] = '0; m_cnt[1] = '0;
    end else if (g && (m_cnt[w] != 16'hFFFF)) begin
      m_cnt[w] = m_cnt[w] + 16'd1;
    end
    check("u2_fsb_v",    i2.fsb_v,    m_v);
    check("u2_fsb_data", i2.fsb_data, m_data);
    check("u2_fsb_src",  i2.fsb_src,  m_src);
    check("u2_gnt_cnt",  gnt_cnt2,    {m_cnt[1], m_cnt[0]});
  endtask

  // Drive the 3-source instance just after a falling edge, then let the
  // combinational yumi settle.
  task automatic drive3(input logic rst, input logic [2:0] v, input logic clr);
    @(negedge clk);
    rst3     = rst;
    clr3     = clr;
    i3.req_v = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_v = 1'b0; m_data = '0; m_src = 1'b0; m_ptr = 1'b0;
    m_cnt[0] = '0; m_cnt[1] = '0;
    d2[0] = 80'h0A; d2[1] = 80'h0B;
    rst2 = 1'b1; clr2 = 1'b0;
    i2.req_v = 2'b00; i2.fsb_ready = 1'b1; i2.req_data = '0;
    rst3 = 1'b1; clr3 = 1'b0;
    i3.req_v = 3'b000; i3.fsb_ready = 1'b1;
    i3.req_data = {80'hC2, 80'hC1, 80'hC0};

    // Reset held for three cycles with every source requesting.
    repeat (3) step2(1'b1, 2'b11, 1'b1, 1'b0);

    // Fair alternation at full rate: 0A, 0B, 0A, 0B starting from source 0.
    repeat (4) step2(1'b0, 2'b11, 1'b1, 1'b0);

    // Backpressure: hold 1234 for five cycles, then reload with no bubble.
    d2[0] = 80'h1234; d2[1] = 80'h5678;
    step2(1'b0, 2'b01, 1'b1, 1'b0);
    repeat (5) step2(1'b0, 2'b11, 1'b0, 1'b0);
    step2(1'b0, 2'b11, 1'b1, 1'b0);
    step2(1'b0, 2'b00, 1'b1, 1'b0);

    // Clearing the counters in the same cycle as a grant.
    step2(1'b0, 2'b01, 1'b1, 1'b1);
    step2(1'b0, 2'b00, 1'b1, 1'b0);

    // Reset while a packet is stalled: the packet must be discarded.
    d2[1] = 80'hDEAD;
    step2(1'b0, 2'b10, 1'b0, 1'b0);
    step2(1'b0, 2'b00, 1'b0, 1'b0);
    step2(1'b1, 2'b00, 1'b0, 1'b0);
    repeat (2) step2(1'b0, 2'b00, 1'b1, 1'b0);
    check("u2_sb_empty", 128'(sb.size()), 128'd0);

    // Three sources: reset first.
    drive3(1'b1, 3'b111, 1'b0);
    check("u3_yumi_rst", i3.req_yumi, 3'b000);
    tick();
    drive3(1'b1, 3'b000, 1'b0);
    tick();
    check("u3_fsb_v_rst", i3.fsb_v, 1'b0);

    // Only source 2 requests: grant to 2, and the pointer wraps to 0.
    drive3(1'b0, 3'b100, 1'b0);
    check("u3_yumi_src2", i3.req_yumi, 3'b100);
    tick();
    check("u3_src2",      i3.fsb_src,  2'd2);
    check("u3_data2",     i3.fsb_data, 80'hC2);
    check("u3_cnt_after2", gnt_cnt3,   12'h100);

    // Sources 0 and 2 request: source 0 wins after the wrap.
    drive3(1'b0, 3'b101, 1'b0);
    check("u3_yumi_wrap", i3.req_yumi, 3'b001);
    tick();
    check("u3_src0",  i3.fsb_src,  2'd0);
    check("u3_data0", i3.fsb_data, 80'hC0);

    // Twenty grants to source 1 saturate its 4-bit counter at 15.
    for (int i = 0; i < 20; i++) begin
      drive3(1'b0, 3'b010, 1'b0);
      check("u3_yumi_src1", i3.req_yumi, 3'b010);
      tick();
    end
    check("u3_cnt1_sat", gnt_cnt3[7:4], 4'd15);
    check("u3_data1",    i3.fsb_data,   80'hC1);

    // A clear in the same cycle as a grant wins, and the grant is not counted.
    drive3(1'b0, 3'b010, 1'b1);
    check("u3_yumi_clr", i3.req_yumi, 3'b010);
    tick();
    check("u3_cnt_clr", gnt_cnt3, 12'h000);
    drive3(1'b0, 3'b010, 1'b0);
    tick();
    check("u3_cnt_post_clr", gnt_cnt3[7:4], 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
